// File: rtl/apu_pkg.sv
// Shared APU constants and small types: length-counter load table, pulse duty
// patterns and the narrow field types used by the pulse and noise channels.
package apu_pkg;

  typedef logic [1:0] duty_t;
  typedef logic [3:0] vol_t;

  localparam vol_t DECAY_MAX = 4'hF;

  // Indexed by write_data[7:3] on a length write.
  localparam logic [7:0] LENGTH_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  // Bit n of each entry is the output level at sequencer position n.
  localparam logic [7:0] DUTY_TABLE [4] = '{
    8'b0000_0010,
    8'b0000_0110,
    8'b0001_1110,
    8'b1111_1001
  };

  function automatic logic duty_bit(input duty_t duty, input logic [2:0] pos);
    logic [7:0] pattern;
    pattern  = DUTY_TABLE[duty];
    duty_bit = pattern[pos];
  endfunction

endpackage

// File: rtl/envelope_unit.sv
// Envelope generator: divider clocked by quarter-frame ticks, 4-bit decay level
// with optional looping. Used by the pulse channels and the noise channel.
module envelope_unit
  import apu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic cpu_en,
  input  logic quarter_frame,
  input  logic restart,
  input  logic loop,
  input  vol_t period,
  output vol_t decay
);

  logic start_flag;
  vol_t divider;

  always_ff @(posedge clk) begin
    if (reset) begin
      start_flag <= 1'b0;
      divider    <= '0;
      decay      <= '0;
    end else if (cpu_en) begin
      if (quarter_frame) begin
        if (start_flag) begin
          decay   <= DECAY_MAX;
          divider <= period;
        end else if (divider == 4'd0) begin
          divider <= period;
          if (decay != 4'd0)
            decay <= decay - 4'd1;
          else if (loop)
            decay <= DECAY_MAX;
        end else begin
          divider <= divider - 4'd1;
        end
      end
      // A restart landing on a tick is seen by the following tick, not this one.
      if (restart)
        start_flag <= 1'b1;
      else if (quarter_frame)
        start_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/pulse_output_stage.sv
// Pulse channel back end: duty sequencer, envelope and length counter producing
// the registered 4-bit channel sample and the length status bit.
module pulse_output_stage
  import apu_pkg::*;
#(
  parameter int CH2 = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_en,
  input  logic       quarter_frame,
  input  logic       half_frame,
  input  logic       next_step,
  input  logic       mute,
  input  logic       write_ctrl,
  input  logic       write_len,
  input  logic [7:0] write_data,
  input  logic       channel_enable,
  output logic [3:0] sample,
  output logic       length_active
);

  if (CH2 != 0 && CH2 != 1) begin : g_bad_channel
    $error("pulse_output_stage: CH2 must be 0 or 1");
  end

  duty_t      duty;
  logic       halt;
  logic       const_vol;
  vol_t       vol;
  logic [2:0] seq_pos;
  logic [7:0] length;
  vol_t       decay;
  logic       length_nz;
  logic       sounding;
  vol_t       level;

  always_ff @(posedge clk) begin
    if (reset) begin
      duty      <= '0;
      halt      <= 1'b0;
      const_vol <= 1'b0;
      vol       <= '0;
    end else if (cpu_en && write_ctrl) begin
      duty      <= write_data[7:6];
      halt      <= write_data[5];
      const_vol <= write_data[4];
      vol       <= write_data[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      seq_pos <= '0;
    else if (cpu_en) begin
      if (write_len)
        seq_pos <= '0;
      else if (next_step)
        seq_pos <= seq_pos + 3'd1;
    end
  end

  // Disable clears the counter every enabled cycle and blocks reloads.
  always_ff @(posedge clk) begin
    if (reset)
      length <= '0;
    else if (cpu_en) begin
      if (!channel_enable)
        length <= '0;
      else if (write_len)
        length <= LENGTH_TABLE[write_data[7:3]];
      else if (half_frame && length_nz && !halt)
        length <= length - 8'd1;
    end
  end

  envelope_unit u_envelope (
    .clk          (clk),
    .reset        (reset),
    .cpu_en       (cpu_en),
    .quarter_frame(quarter_frame),
    .restart      (write_len),
    .loop         (halt),
    .period       (vol),
    .decay        (decay)
  );

  assign length_nz     = (length != 8'd0);
  assign length_active = length_nz;
  assign sounding      = duty_bit(duty, seq_pos) & length_nz & ~mute;
  assign level         = const_vol ? vol : decay;

  // Sample tracks every clock so mute reaches the mixer without waiting on cpu_en.
  always_ff @(posedge clk) begin
    if (reset)
      sample <= '0;
    else
      sample <= sounding ? level : 4'd0;
  end

endmodule

// File: tb/tb_pulse_output_stage.sv
// Directed vector bench for pulse_output_stage: one operation cycle, one idle
// cycle, then compare sample and length_active against hand-computed values.
module tb_pulse_output_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_en;
  logic       quarter_frame;
  logic       half_frame;
  logic       next_step;
  logic       mute;
  logic       write_ctrl;
  logic       write_len;
  logic [7:0] write_data;
  logic       channel_enable;
  logic [3:0] sample;
  logic       length_active;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       cpu_en;
    logic       qf;
    logic       hf;
    logic       ns;
    logic       mute;
    logic       wc;
    logic       wl;
    logic [7:0] data;
    logic       ch_en;
    logic [3:0] exp_sample;
    logic       exp_la;
  } vec_t;

  vec_t vecs[$];

  pulse_output_stage #(.CH2(0)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_en        (cpu_en),
    .quarter_frame (quarter_frame),
    .half_frame    (half_frame),
    .next_step     (next_step),
    .mute          (mute),
    .write_ctrl    (write_ctrl),
    .write_len     (write_len),
    .write_data    (write_data),
    .channel_enable(channel_enable),
    .sample        (sample),
    .length_active (length_active)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic ce, input logic qf, input logic hf, input logic ns,
                              input logic mu, input logic wc, input logic wl, input logic [7:0] d,
                              input logic en, input logic [3:0] es, input logic ela);
    vec_t v;
    v.cpu_en = ce; v.qf = qf; v.hf = hf; v.ns = ns; v.mute = mu;
    v.wc = wc; v.wl = wl; v.data = d; v.ch_en = en;
    v.exp_sample = es; v.exp_la = ela;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [3:0] exp_s, input logic exp_la);
    checks++;
    if (sample !== exp_s) begin
      failures++;
      $display("FAIL %s[%0d] sample: got %0d expected %0d", name, idx, sample, exp_s);
    end
    checks++;
    if (length_active !== exp_la) begin
      failures++;
      $display("FAIL %s[%0d] length_active: got %0b expected %0b", name, idx, length_active, exp_la);
    end
  endtask

  // Operation cycle, then an idle cycle (same mute/enable) so the registered
  // sample reflects the state left by the operation.
  task automatic apply(input vec_t v);
    @(negedge clk);
    cpu_en = v.cpu_en; quarter_frame = v.qf; half_frame = v.hf; next_step = v.ns;
    mute = v.mute; write_ctrl = v.wc; write_len = v.wl; write_data = v.data;
    channel_enable = v.ch_en;
    @(negedge clk);
    cpu_en = 1'b1; quarter_frame = 1'b0; half_frame = 1'b0; next_step = 1'b0;
    write_ctrl = 1'b0; write_len = 1'b0; write_data = 8'h00;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cpu_en = 1'b0; quarter_frame = 1'b0; half_frame = 1'b0;
    next_step = 1'b0; mute = 1'b0; write_ctrl = 1'b0; write_len = 1'b0;
    write_data = 8'h00; channel_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset", 0, 4'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    //                ce qf hf ns mu wc wl data   en  smp la
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 8'hBF, 1,  0, 0)); // duty 2, const 15
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 8'h08, 1,  0, 1)); // length 254, pos 0
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 8'h00, 1, 15, 1)); // pos 1
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 8'h00, 1, 15, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 8'h00, 1, 15, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 8'h00, 1, 15, 1)); // pos 4
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 8'h00, 1,  0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 8'h00, 1,  0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 8'h00, 1,  0, 1)); // pos 7
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 8'h00, 1,  0, 1)); // wrap to 0
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 8'h00, 1, 15, 1)); // pos 1
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 8'h00, 1,  0, 1)); // muted
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 1, 15, 1)); // unmuted
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'h00, 1, 15, 1)); // step ignored
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 1, 8'h08, 1,  0, 1)); // reload beats step
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 8'h00, 1, 15, 1)); // pos 1
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 8'h3F, 1, 15, 1)); // duty 0 at pos 1
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 8'h00, 1,  0, 1)); // pos 2
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 8'hFF, 1,  0, 1)); // duty 3 at pos 2
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 8'h00, 1, 15, 1)); // pos 3
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 8'h7F, 1,  0, 1)); // duty 1 at pos 3
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 8'hDF, 1, 15, 1)); // duty 3, no halt
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 8'h18, 1, 15, 1)); // length 2
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 8'h00, 1, 15, 1)); // length 1
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 8'h00, 1,  0, 0)); // length 0
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 8'h00, 1,  0, 0)); // no wrap
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1, 8'h18, 1, 15, 1)); // load beats decrement
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 8'h00, 1, 15, 1)); // length 1
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 8'h00, 1,  0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 8'hFF, 1,  0, 0)); // halt set
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 8'h18, 1, 15, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 8'h00, 1, 15, 1)); // halted
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 8'h00, 1, 15, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 0,  0, 0)); // disable clears
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 8'h18, 0,  0, 0)); // load blocked
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 1,  0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 8'hC3, 1,  0, 0)); // envelope, period 3
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 8'h08, 1,  0, 1)); // decay still 0

    foreach (vecs[i]) begin
      apply(vecs[i]);
      check("vec", i, vecs[i].exp_sample, vecs[i].exp_la);
    end

    // Envelope decay: 15 on the first tick, one step down every 4 ticks, holds at 0.
    for (int t = 1; t <= 70; t++) begin
      int lvl;
      lvl = 15 - (t - 1) / 4;
      if (lvl < 0) lvl = 0;
      apply(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 1, 4'(lvl), 1));
      check("env_decay", t, 4'(lvl), 1'b1);
    end

    // Loop enabled: divider is at 2 after tick 70, so tick 73 wraps 0 -> 15.
    apply(mk(1, 0, 0, 0, 0, 1, 0, 8'hE3, 1, 0, 1));
    check("env_loop_set", 0, 4'd0, 1'b1);
    apply(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 1, 0, 1));
    check("env_loop", 71, 4'd0, 1'b1);
    apply(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 1, 0, 1));
    check("env_loop", 72, 4'd0, 1'b1);
    apply(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 1, 15, 1));
    check("env_loop", 73, 4'd15, 1'b1);
    apply(mk(1, 1, 0, 0, 0, 0, 0, 8'h00, 1, 15, 1));
    check("env_loop", 74, 4'd15, 1'b1);

    // Reset wins even with cpu_en low.
    @(negedge clk);
    reset = 1'b1; cpu_en = 1'b0;
    @(posedge clk);
    #1;
    check("reset_no_en", 0, 4'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_output_stage.md
Name: pulse_output_stage

Overview:
Downstream consumer of the pulse timer/sweep stage. Turns its per-period step strobe and mute flag into the 4-bit pulse channel sample. Contains the 8-step duty sequencer, the envelope generator and the length counter. One instance per pulse channel; the sample feeds the APU mixer, and length status feeds the $4015 read path.

Parameters:
CH2, 0, channel index (0 = pulse 1, 1 = pulse 2); identification only, no behavioural difference in this block.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high system reset
cpu_en  in  1  CPU-rate enable; all state updates except the sample register are gated by it
quarter_frame  in  1  frame-sequencer quarter-frame tick (envelope)
half_frame  in  1  frame-sequencer half-frame tick (length counter)
next_step  in  1  timer underflow strobe from the timer/sweep stage
mute  in  1  sweep/low-period mute from the timer/sweep stage
write_ctrl  in  1  CPU write to $4000/$4004
write_len  in  1  CPU write to $4003/$4007
write_data  in  8  CPU write data
channel_enable  in  1  $4015 enable bit for this channel (level)
sample  out  4  channel output level
length_active  out  1  length counter != 0

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset: duty=0, halt=0, const_vol=0, vol=0, seq_pos=0, decay=0, divider=0, start_flag=0, length=0, sample=0, length_active=0. Reset applies regardless of cpu_en.
- All events below are evaluated only when cpu_en=1. They use pre-update register values; there is no same-cycle forwarding of write_ctrl fields.
- write_ctrl fields: duty<=d[7:6], halt (also envelope loop)<=d[5], const_vol<=d[4], vol<=d[3:0].
- write_len actions:
  - seq_pos<=0.
  - start_flag<=1.
  - If channel_enable=1, length<=LENGTH_TABLE[d[7:3]]; otherwise length is unchanged (remains 0).
- Sequencer: on next_step, seq_pos<=seq_pos+1, wrapping 7->0. If write_len and next_step occur together, write_len wins (seq_pos=0).
- Duty bit = DUTY[duty][seq_pos], with patterns listed for seq_pos 0..7:
  - duty 0: 0 1 0 0 0 0 0 0
  - duty 1: 0 1 1 0 0 0 0 0
  - duty 2: 0 1 1 1 1 0 0 0
  - duty 3: 1 0 0 1 1 1 1 1
- Envelope, on quarter_frame:
  - If start_flag=1: start_flag<=0, decay<=15, divider<=vol.
  - Else if divider==0: divider<=vol. Then, if decay!=0, decay<=decay-1; else if halt=1, decay<=15; else decay holds at 0.
  - Else: divider<=divider-1.
  - If write_len and quarter_frame occur together, start_flag is set (1) and the quarter_frame step uses the old start_flag.
- Length counter:
  - channel_enable=0 forces length<=0 every cpu_en cycle; this has priority over everything else.
  - On half_frame with length!=0 and halt=0: length<=length-1. Decrement stops at 0 (no wrap).
  - If write_len and half_frame occur together (channel enabled), the load wins.
- LENGTH_TABLE[0..31] = 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30. Length is 8 bits wide.
- Output:
  - sample register updates every clk (not gated by cpu_en), one cycle of latency from the state and mute.
  - sample <= (duty_bit & length!=0 & ~mute) ? (const_vol ? vol : decay) : 0.
  - length_active is combinational: length!=0.

Decomposition:
- Package apu_pkg:
  - LENGTH_TABLE (32 x 8-bit constant)
  - DUTY_TABLE (4 x 8-bit constant)
  - typedef duty_t (2-bit)
  - typedef vol_t (4-bit)
- Sub-module envelope_unit:
  - Inputs: clk, reset, cpu_en, quarter_frame, restart, loop, period.
  - Output: decay.
  - Shared later with the noise channel.
- Length counter and sequencer stay inline.

Test Plan:
- Reset, then check outputs -> sample=0, length_active=0. Enable, write_ctrl=0xBF (duty 2, halt, const vol 15), write_len=0x08 (idx 1) -> length=254. Apply 8 next_step pulses -> sample sequence 0,15,15,15,15,0,0,0 (one cycle after each step), then repeats.
- write_ctrl=0x03 (envelope, period 3, no loop), write_len, then quarter_frame ticks -> decay 15 after first tick, decrements every 4 ticks, reaches 0 and holds. With write_ctrl=0x23 (loop) -> 0 wraps to 15.
- write_len=0x18 (idx 3, length 2), halt=0, two half_frame ticks -> length_active 1,1,0 and sample forced to 0. Drop channel_enable mid-count -> length=0 on the next cpu_en cycle. write_len while disabled -> length stays 0.
- Same-cycle write_len and half_frame -> length equals the table value, not table-1. Same-cycle write_len and next_step -> seq_pos=0.
- mute=1 with all other conditions sounding -> sample=0 next clk. Release mute -> sample is restored. cpu_en=0 with next_step=1 -> seq_pos unchanged.
